// File: rtl/proc_clock_ctrl.sv
`timescale 1ns/1ps
// proc_clock_ctrl
//   Controllable processor clock source. Two debounced push buttons select
//   between single-step (one proc_clk pulse per STEP press) and free-running
//   mode (one pulse every RUN_DIV cycles). The processor may request a halt,
//   which suspends pulse generation until MODE is pressed again.
//
// Ports
//   clock       in   board clock
//   reset       in   asynchronous, active-high reset
//   step_btn_n  in   raw STEP button, active-low, asynchronous
//   mode_btn_n  in   raw MODE button, active-low, asynchronous
//   halt        in   processor halt request, synchronous to clock
//   proc_clk    out  registered processor clock
//   proc_tick   out  one-cycle strobe in the cycle proc_clk rises
//   run_mode    out  state is RUN
//   halted      out  state is HALT
//   tick_count  out  proc_clk rising edges since reset, wraps
module proc_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25,
  parameter int HIGH_CYCLES     = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_btn_n,
  input  logic             mode_btn_n,
  input  logic             halt,
  output logic             proc_clk,
  output logic             proc_tick,
  output logic             run_mode,
  output logic             halted,
  output logic [CNT_W-1:0] tick_count
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam int PT_W  = $clog2(2 * HIGH_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [PT_W-1:0]  PT_LAST  = PT_W'(2 * HIGH_CYCLES);
  localparam logic [PT_W-1:0]  PT_HIGH  = PT_W'(HIGH_CYCLES);
  localparam logic [PT_W-1:0]  PT_ONE   = PT_W'(1);

  typedef enum logic [1:0] {
    ST_STEP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Bit 0 is STEP, bit 1 is MODE.
  logic [1:0] w_raw_n;
  logic [1:0] w_press;
  logic       w_step_press;
  logic       w_mode_press;

  assign w_raw_n      = {mode_btn_n, step_btn_n};
  assign w_step_press = w_press[0];
  assign w_mode_press = w_press[1];

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic            r_meta;
    logic            r_sync;
    logic            r_db;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_meta <= 1'b1;
        r_sync <= 1'b1;
      end else begin
        r_meta <= w_raw_n[g];
        r_sync <= r_meta;
      end
    end

    // Debounce: accept a new level only after it has disagreed with the
    // current level for DEBOUNCE_CYCLES consecutive cycles. A press pulse
    // is raised together with the 1->0 update of the debounced level.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt   <= '0;
        r_db    <= 1'b1;
        r_press <= 1'b0;
      end else begin
        r_press <= 1'b0;
        if (r_sync == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          r_cnt   <= '0;
          r_db    <= r_sync;
          r_press <= ~r_sync;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[g] = r_press;
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_div_nxt;
  logic [PT_W-1:0]    r_pt;
  logic [PT_W-1:0]    w_pt_nxt;
  logic               w_req;
  logic               w_gen_idle;
  logic               r_proc_clk;
  logic               r_tick;
  logic               r_run_mode;
  logic               r_halted;
  logic [CNT_W-1:0]   r_tick_count;

  // Pulse generator is free once the full high+low window has elapsed.
  assign w_gen_idle = (r_pt == '0);

  // Mode FSM next-state and pulse request. The divider is held at zero
  // outside RUN so it restarts from zero on every RUN entry. A RUN request
  // is only issued when the FSM stays in RUN that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = '0;
    w_req       = 1'b0;
    case (r_state)
      ST_STEP: begin
        if (w_mode_press) begin
          w_state_nxt = ST_RUN;
        end else if (w_step_press && w_gen_idle) begin
          w_req = 1'b1;
        end else begin
          w_req = 1'b0;
        end
      end
      ST_RUN: begin
        if (halt) begin
          w_state_nxt = ST_HALT;
        end else if (w_mode_press) begin
          w_state_nxt = ST_STEP;
        end else if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          w_req     = w_gen_idle;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      ST_HALT: begin
        if (w_mode_press) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt = ST_STEP;
      end
    endcase
  end

  // Pulse timer: 1..HIGH_CYCLES is the high phase, the rest up to
  // 2*HIGH_CYCLES is the guaranteed low phase, 0 means idle.
  always_comb begin
    w_pt_nxt = r_pt;
    if (w_req) begin
      w_pt_nxt = PT_ONE;
    end else if (r_pt == '0) begin
      w_pt_nxt = '0;
    end else if (r_pt == PT_LAST) begin
      w_pt_nxt = '0;
    end else begin
      w_pt_nxt = r_pt + 1'b1;
    end
  end

  // State, divider, pulse timer and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_STEP;
      r_div        <= '0;
      r_pt         <= '0;
      r_proc_clk   <= 1'b0;
      r_tick       <= 1'b0;
      r_run_mode   <= 1'b0;
      r_halted     <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_pt       <= w_pt_nxt;
      r_proc_clk <= (w_pt_nxt != '0) && (w_pt_nxt <= PT_HIGH);
      r_tick     <= w_req;
      r_run_mode <= (w_state_nxt == ST_RUN);
      r_halted   <= (w_state_nxt == ST_HALT);
      if (w_req) begin
        r_tick_count <= r_tick_count + 1'b1;
      end else begin
        r_tick_count <= r_tick_count;
      end
    end
  end

  assign proc_clk   = r_proc_clk;
  assign proc_tick  = r_tick;
  assign run_mode   = r_run_mode;
  assign halted     = r_halted;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_proc_clock_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for proc_clock_ctrl: directed scenarios followed by
// randomized button/halt activity, all compared cycle by cycle against a
// behavioural model built from edge indices and sample windows.
module tb_proc_clock_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;
  localparam int HI  = 2;
  localparam int CW  = 4;

  logic          clock;
  logic          reset;
  logic          step_btn_n;
  logic          mode_btn_n;
  logic          halt;
  logic          proc_clk;
  logic          proc_tick;
  logic          run_mode;
  logic          halted;
  logic [CW-1:0] tick_count;

  proc_clock_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .RUN_DIV         (DIV),
    .HIGH_CYCLES     (HI),
    .CNT_W           (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .step_btn_n (step_btn_n),
    .mode_btn_n (mode_btn_n),
    .halt       (halt),
    .proc_clk   (proc_clk),
    .proc_tick  (proc_tick),
    .run_mode   (run_mode),
    .halted     (halted),
    .tick_count (tick_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edge n is the n-th rising clock edge since reset release. A button's
  // debounced level flips at edge n when the raw samples taken at edges
  // n-2 .. n-DEB-1 all disagree with it; a press becomes visible to the
  // mode logic one edge later.
  int              m_edge;
  logic [DEB+1:0]  m_hist_s, m_hist_m;   // bit k = raw sample at edge n-k
  logic            m_db_s, m_db_m;
  logic            m_press_s, m_press_m;
  int              m_state;              // 0 step, 1 run, 2 halt
  int              m_entry;
  int              m_last_rise;
  bit              m_has_rise;
  int              m_count;
  bit              m_tick;

  function automatic logic window_flips(input logic [DEB+1:0] h, input logic d);
    for (int k = 2; k < DEB + 2; k++) begin
      if (h[k] == d) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_clk();
    return m_has_rise && ((m_edge - m_last_rise) < HI);
  endfunction

  task automatic model_reset();
    m_edge      = 0;
    m_hist_s    = '1;
    m_hist_m    = '1;
    m_db_s      = 1'b1;
    m_db_m      = 1'b1;
    m_press_s   = 1'b0;
    m_press_m   = 1'b0;
    m_state     = 0;
    m_entry     = 0;
    m_last_rise = 0;
    m_has_rise  = 1'b0;
    m_count     = 0;
    m_tick      = 1'b0;
  endtask

  task automatic model_step();
    bit mp, sp, idle, req;
    m_edge++;
    mp   = m_press_m;
    sp   = m_press_s;
    idle = !m_has_rise || ((m_edge - m_last_rise) > 2 * HI);
    req  = 1'b0;
    case (m_state)
      0: begin
        if (mp) begin
          m_state = 1;
          m_entry = m_edge;
        end else if (sp && idle) begin
          req = 1'b1;
        end
      end
      1: begin
        if (halt) m_state = 2;
        else if (mp) m_state = 0;
        else if (((m_edge - 1 - m_entry) % DIV) == DIV - 1 && idle) req = 1'b1;
      end
      default: begin
        if (mp) m_state = 0;
      end
    endcase
    m_tick = req;
    if (req) begin
      m_last_rise = m_edge;
      m_has_rise  = 1'b1;
      m_count     = (m_count + 1) % (1 << CW);
    end
    m_hist_s  = {m_hist_s[DEB:0], step_btn_n};
    m_hist_m  = {m_hist_m[DEB:0], mode_btn_n};
    m_press_s = 1'b0;
    m_press_m = 1'b0;
    if (window_flips(m_hist_s, m_db_s)) begin
      m_db_s    = ~m_db_s;
      m_press_s = ~m_db_s;
    end
    if (window_flips(m_hist_m, m_db_m)) begin
      m_db_m    = ~m_db_m;
      m_press_m = ~m_db_m;
    end
  endtask

  // One clock: advance the model at the rising edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("proc_clk",   proc_clk,   exp_clk());
    check("proc_tick",  proc_tick,  m_tick);
    check("run_mode",   run_mode,   m_state == 1);
    check("halted",     halted,     m_state == 2);
    check("tick_count", tick_count, m_count);
  endtask

  // Assert reset wherever we are, check the immediate effect, release on a falling edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_proc_clk",   proc_clk,   0);
    check("rst_proc_tick",  proc_tick,  0);
    check("rst_run_mode",   run_mode,   0);
    check("rst_halted",     halted,     0);
    check("rst_tick_count", tick_count, 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, hi_cnt, t_first, t_run, base, got, s_hold, m_hold;
    reset      = 1'b1;
    step_btn_n = 1'b1;
    mode_btn_n = 1'b1;
    halt       = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    // 1: single STEP press
    step_btn_n = 1'b0;
    ticks = 0; hi_cnt = 0; t_first = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (proc_tick) begin
        ticks++;
        if (t_first == 0) t_first = k;
      end
      if (proc_clk) hi_cnt++;
    end
    check("s1_ticks", ticks, 1);
    check("s1_tick_cycle", t_first, 7);
    check("s1_high_cycles", hi_cnt, 2);
    check("s1_count", tick_count, 1);
    check("s1_run_mode", run_mode, 0);
    step_btn_n = 1'b1;
    repeat (10) cycle();

    // 2: bounce rejection
    do_reset();
    ticks = 0;
    for (int r = 0; r < 5; r++) begin
      step_btn_n = 1'b0;
      for (int k = 0; k < 3; k++) begin cycle(); if (proc_tick) ticks++; end
      step_btn_n = 1'b1;
      for (int k = 0; k < 3; k++) begin cycle(); if (proc_tick) ticks++; end
    end
    repeat (10) begin cycle(); if (proc_tick) ticks++; end
    check("s2_ticks", ticks, 0);
    check("s2_count", tick_count, 0);

    // 3: run mode
    mode_btn_n = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle();
      if (run_mode) got = 1;
    end
    check("s3_enter_run", got, 1);
    ticks = 0; t_first = 0; base = int'(tick_count);
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) mode_btn_n = 1'b1;
      cycle();
      if (proc_tick) begin
        ticks++;
        if (t_first == 0) t_first = k;
      end
    end
    check("s3_ticks", ticks, 12);
    check("s3_first_tick", t_first, 8);
    check("s3_count_delta", (int'(tick_count) - base + 16) % 16, 12);

    // 4: halt on the cycle proc_clk rises
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle();
      if (proc_tick) got = 1;
    end
    check("s4_rise_seen", got, 1);
    halt = 1'b1;
    cycle();
    check("s4_halted", halted, 1);
    check("s4_clk_hold", proc_clk, 1);
    halt = 1'b0;
    cycle();
    check("s4_clk_low", proc_clk, 0);
    ticks = 0;
    for (int k = 1; k <= 50; k++) begin
      step_btn_n = (k >= 5 && k < 20) ? 1'b0 : 1'b1;
      cycle();
      if (proc_tick) ticks++;
    end
    check("s4_no_ticks", ticks, 0);
    check("s4_still_halted", halted, 1);
    mode_btn_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 10) mode_btn_n = 1'b1;
      cycle();
    end
    check("s4_exit_run", run_mode, 0);
    check("s4_exit_halted", halted, 0);

    // 5: STEP and MODE pressed together
    repeat (10) cycle();
    step_btn_n = 1'b0;
    mode_btn_n = 1'b0;
    t_run = 0; t_first = 0; base = int'(tick_count);
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) begin
        step_btn_n = 1'b1;
        mode_btn_n = 1'b1;
      end
      cycle();
      if (run_mode && t_run == 0) t_run = k;
      if (proc_tick && t_first == 0) t_first = k;
    end
    check("s5_run_mode", run_mode, 1);
    check("s5_first_tick_offset", t_first - t_run, 8);
    check("s5_count_delta", (int'(tick_count) - base + 16) % 16, 1);

    // 6: asynchronous reset while proc_clk is high
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      cycle();
      if (proc_clk) got = 1;
    end
    check("s6_clk_high_seen", got, 1);
    #2;
    do_reset();

    // Randomized button and halt activity
    s_hold = 0;
    m_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      if (s_hold == 0) begin
        step_btn_n = 1'($urandom_range(0, 1));
        s_hold     = $urandom_range(1, 14);
      end else begin
        s_hold--;
      end
      if (m_hold == 0) begin
        mode_btn_n = 1'($urandom_range(0, 1));
        m_hold     = $urandom_range(1, 40);
      end else begin
        m_hold--;
      end
      halt = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
